// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file with write-through
// bypass, immediate generator, control decoder and ID/EX register.
module id_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [3:0]      alu_op_o,
    output logic            asel_o,
    output logic            bsel_o,
    output logic            regwen_o,
    output logic            memrd_o,
    output logic            memwr_o,
    output logic [1:0]      wbsel_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic [2:0]      funct3_o,
    output logic            illegal_o
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            asel;
        logic            bsel;
        logic            regwen;
        logic            memrd;
        logic            memwr;
        logic [1:0]      wbsel;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
    } id_ex_t;

    logic [XLEN-1:0] rf [32];
    id_ex_t          dec;
    id_ex_t          nxt;
    id_ex_t          q;
    logic            legal;
    logic            wen;
    logic [3:0]      alu_base;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign rd     = instr_i[11:7];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_fence, is_system;

    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_fence  = (opcode == OPC_FENCE);
    assign is_system = (opcode == OPC_SYSTEM);

    // Map funct3 onto the non-alternate ALU operation.
    always_comb begin
        alu_base = ALU_ADD;
        unique case (f3)
            3'b000: alu_base = ALU_ADD;
            3'b001: alu_base = ALU_SLL;
            3'b010: alu_base = ALU_SLT;
            3'b011: alu_base = ALU_SLTU;
            3'b100: alu_base = ALU_XOR;
            3'b101: alu_base = ALU_SRL;
            3'b110: alu_base = ALU_OR;
            3'b111: alu_base = ALU_AND;
        endcase
    end

    // Main decoder: fields, immediate and control per opcode.
    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        dec.pc     = pc_i;
        dec.instr  = instr_i;
        dec.alu_op = ALU_ADD;
        legal      = 1'b1;
        wen        = 1'b0;
        unique case (1'b1)
            is_lui: begin
                dec.rd     = rd;
                dec.imm    = imm_u;
                dec.bsel   = 1'b1;
                dec.alu_op = ALU_PASSB;
                wen        = 1'b1;
            end
            is_auipc: begin
                dec.rd   = rd;
                dec.imm  = imm_u;
                dec.asel = 1'b1;
                dec.bsel = 1'b1;
                wen      = 1'b1;
            end
            is_jal: begin
                dec.rd    = rd;
                dec.imm   = imm_j;
                dec.asel  = 1'b1;
                dec.bsel  = 1'b1;
                dec.wbsel = 2'd2;
                dec.jump  = 1'b1;
                wen       = 1'b1;
            end
            is_jalr: begin
                dec.rs1    = rs1;
                dec.rd     = rd;
                dec.imm    = imm_i;
                dec.bsel   = 1'b1;
                dec.wbsel  = 2'd2;
                dec.jump   = 1'b1;
                dec.funct3 = f3;
                wen        = 1'b1;
                legal      = (f3 == 3'b000);
            end
            is_branch: begin
                dec.rs1    = rs1;
                dec.rs2    = rs2;
                dec.imm    = imm_b;
                dec.asel   = 1'b1;
                dec.bsel   = 1'b1;
                dec.branch = 1'b1;
                dec.funct3 = f3;
                legal      = (f3[2:1] != 2'b01);
            end
            is_load: begin
                dec.rs1    = rs1;
                dec.rd     = rd;
                dec.imm    = imm_i;
                dec.bsel   = 1'b1;
                dec.memrd  = 1'b1;
                dec.wbsel  = 2'd1;
                dec.funct3 = f3;
                wen        = 1'b1;
                legal      = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            is_store: begin
                dec.rs1    = rs1;
                dec.rs2    = rs2;
                dec.imm    = imm_s;
                dec.bsel   = 1'b1;
                dec.memwr  = 1'b1;
                dec.funct3 = f3;
                legal      = !f3[2] && (f3 != 3'b011);
            end
            is_opimm: begin
                dec.rs1    = rs1;
                dec.rd     = rd;
                dec.imm    = imm_i;
                dec.bsel   = 1'b1;
                dec.funct3 = f3;
                dec.alu_op = alu_base;
                wen        = 1'b1;
                if (f3 == 3'b001) begin
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    if (f7[5]) dec.alu_op = ALU_SRA;
                end
            end
            is_op: begin
                dec.rs1    = rs1;
                dec.rs2    = rs2;
                dec.rd     = rd;
                dec.funct3 = f3;
                dec.alu_op = alu_base;
                wen        = 1'b1;
                if (f7 == F7_ALT) begin
                    legal      = (f3 == 3'b000) || (f3 == 3'b101);
                    dec.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else begin
                    legal = (f7 == F7_BASE);
                end
            end
            is_fence: begin
                legal = (f3 == 3'b000);
            end
            is_system: begin
                legal = (instr_i == 32'h0000_0073)
                     || (instr_i == 32'h0010_0073);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.illegal = 1'b1;
            wen         = 1'b0;
            dec.memrd   = 1'b0;
            dec.memwr   = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = 1'b0;
        end
        dec.regwen = wen && (dec.rd != 5'd0);
    end

    // Operand read with same-cycle write-back forwarded through.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (dec.rs1 != 5'd0)
            rd1 = (wb_we && wb_rd == dec.rs1) ? wb_data : rf[dec.rs1];
        if (dec.rs2 != 5'd0)
            rd2 = (wb_we && wb_rd == dec.rs2) ? wb_data : rf[dec.rs2];
    end

    // Merge decoded control with the operand values.
    always_comb begin
        nxt          = dec;
        nxt.rs1_data = rd1;
        nxt.rs2_data = rd2;
    end

    // Register file; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // ID/EX boundary: flush beats stall, stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= '0;
            q.instr <= NOP_INSTR;
        end else if (flush) begin
            q       <= '0;
            q.pc    <= pc_i;
            q.instr <= NOP_INSTR;
        end else if (en) begin
            q <= nxt;
        end
    end

    assign valid_o    = q.valid;
    assign pc_o       = q.pc;
    assign instr_o    = q.instr;
    assign rs1_o      = q.rs1;
    assign rs2_o      = q.rs2;
    assign rd_o       = q.rd;
    assign rs1_data_o = q.rs1_data;
    assign rs2_data_o = q.rs2_data;
    assign imm_o      = q.imm;
    assign alu_op_o   = q.alu_op;
    assign asel_o     = q.asel;
    assign bsel_o     = q.bsel;
    assign regwen_o   = q.regwen;
    assign memrd_o    = q.memrd;
    assign memwr_o    = q.memwr;
    assign wbsel_o    = q.wbsel;
    assign branch_o   = q.branch;
    assign jump_o     = q.jump;
    assign funct3_o   = q.funct3;
    assign illegal_o  = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed vector table, hand sequences
// and randomized traffic against a behavioural decode model.
module tb_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [3:0] ALU_TAB [8] = '{
        4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9
    };
    localparam logic [6:0] OPCS [11] = '{
        7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
        7'h23, 7'h13, 7'h33, 7'h0F, 7'h73
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic [3:0]  alu_op_o;
    logic        asel_o;
    logic        bsel_o;
    logic        regwen_o;
    logic        memrd_o;
    logic        memwr_o;
    logic [1:0]  wbsel_o;
    logic        branch_o;
    logic        jump_o;
    logic [2:0]  funct3_o;
    logic        illegal_o;

    id_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .pc_i(pc_i), .instr_i(instr_i),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .alu_op_o(alu_op_o),
        .asel_o(asel_o), .bsel_o(bsel_o), .regwen_o(regwen_o),
        .memrd_o(memrd_o), .memwr_o(memwr_o), .wbsel_o(wbsel_o),
        .branch_o(branch_o), .jump_o(jump_o),
        .funct3_o(funct3_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        asel;
        logic        bsel;
        logic        regwen;
        logic        memrd;
        logic        memwr;
        logic [1:0]  wbsel;
        logic        branch;
        logic        jump;
        logic [2:0]  funct3;
        logic        illegal;
    } out_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        asel;
        logic        bsel;
        logic        regwen;
        logic        memrd;
        logic        memwr;
        logic [1:0]  wbsel;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [4:0]  rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_rf [32];
    out_t        exp_q;
    vec_t        tbl [13];

    function automatic out_t got();
        out_t o;
        o = '{valid_o, pc_o, instr_o, rs1_o, rs2_o, rd_o,
              rs1_data_o, rs2_data_o, imm_o, alu_op_o,
              asel_o, bsel_o, regwen_o, memrd_o, memwr_o,
              wbsel_o, branch_o, jump_o, funct3_o, illegal_o};
        return o;
    endfunction

    function automatic out_t rst_val();
        out_t o;
        o       = '0;
        o.instr = NOP;
        return o;
    endfunction

    function automatic out_t ctrl_view(input out_t v);
        out_t o;
        o         = '0;
        o.valid   = v.valid;
        o.pc      = v.pc;
        o.instr   = v.instr;
        o.regwen  = v.regwen;
        o.memrd   = v.memrd;
        o.memwr   = v.memwr;
        o.branch  = v.branch;
        o.jump    = v.jump;
        o.illegal = v.illegal;
        return o;
    endfunction

    // Behavioural RV32I decoder reading the reference register file.
    function automatic out_t ref_decode(input logic [31:0] ins,
                                        input logic [31:0] pc);
        out_t       o;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         u1, u2, ud, hf, wr, ok;
        int         sx, sgn, ii;
        o = '0;
        o.valid = 1'b1;
        o.pc    = pc;
        o.instr = ins;
        f3 = ins[14:12];
        f7 = ins[31:25];
        sx  = int'($signed(ins));
        sgn = sx >>> 31;
        ii  = sx >>> 20;
        u1 = 0; u2 = 0; ud = 0; hf = 0; wr = 0; ok = 1;
        case (ins[6:0])
            7'h37: begin
                ud = 1; wr = 1;
                o.imm = ins & 32'hFFFF_F000;
                o.bsel = 1; o.alu_op = 4'd10;
            end
            7'h17: begin
                ud = 1; wr = 1;
                o.imm = ins & 32'hFFFF_F000;
                o.asel = 1; o.bsel = 1;
            end
            7'h6F: begin
                ud = 1; wr = 1;
                o.imm = (sgn << 20) | (32'(ins[19:12]) << 12)
                      | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                o.asel = 1; o.bsel = 1; o.wbsel = 2; o.jump = 1;
            end
            7'h67: begin
                u1 = 1; ud = 1; wr = 1; hf = 1;
                o.imm = ii;
                o.bsel = 1; o.wbsel = 2; o.jump = 1;
                ok = (f3 == 0);
            end
            7'h63: begin
                u1 = 1; u2 = 1; hf = 1;
                o.imm = (sgn << 12) | (32'(ins[7]) << 11)
                      | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                o.asel = 1; o.bsel = 1; o.branch = 1;
                ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
            end
            7'h03: begin
                u1 = 1; ud = 1; wr = 1; hf = 1;
                o.imm = ii;
                o.bsel = 1; o.memrd = 1; o.wbsel = 1;
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            7'h23: begin
                u1 = 1; u2 = 1; hf = 1;
                o.imm = (ii & ~32'h1F) | 32'(ins[11:7]);
                o.bsel = 1; o.memwr = 1;
                ok = f3 inside {3'd0, 3'd1, 3'd2};
            end
            7'h13: begin
                u1 = 1; ud = 1; wr = 1; hf = 1;
                o.imm = ii;
                o.bsel = 1;
                o.alu_op = ALU_TAB[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = f7 inside {7'h00, 7'h20};
                    if (f7 == 7'h20) o.alu_op = 4'd7;
                end
            end
            7'h33: begin
                u1 = 1; u2 = 1; ud = 1; wr = 1; hf = 1;
                o.alu_op = ALU_TAB[f3];
                if (f7 == 7'h20 && f3 inside {3'd0, 3'd5})
                    o.alu_op = ALU_TAB[f3] + 4'd1;
                else if (f7 != 7'h00)
                    ok = 0;
            end
            7'h0F:   ok = (f3 == 0);
            7'h73:   ok = ins inside {32'h0000_0073, 32'h0010_0073};
            default: ok = 0;
        endcase
        if (u1) o.rs1 = ins[19:15];
        if (u2) o.rs2 = ins[24:20];
        if (ud) o.rd  = ins[11:7];
        if (hf) o.funct3 = f3;
        o.rs1_data = ref_rf[o.rs1];
        o.rs2_data = ref_rf[o.rs2];
        o.regwen   = wr && ok && (o.rd != 0);
        if (!ok) begin
            o.illegal = 1; o.memrd = 0; o.memwr = 0;
            o.branch = 0; o.jump = 0;
        end
        return o;
    endfunction

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic cmp_model(input string nm);
        if (exp_q.illegal)
            check(nm, 256'(ctrl_view(got())), 256'(ctrl_view(exp_q)));
        else
            check(nm, 256'(got()), 256'(exp_q));
    endtask

    // Advance the model by one edge, clock the DUT, compare.
    task automatic tick(input string nm);
        if (wb_we && wb_rd != 0) ref_rf[wb_rd] = wb_data;
        if (flush) begin
            exp_q       = '0;
            exp_q.pc    = pc_i;
            exp_q.instr = NOP;
        end else if (en) begin
            exp_q = ref_decode(instr_i, pc_i);
        end
        @(posedge clk);
        #1;
        cmp_model(nm);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k == 11) return r;
        r[6:0] = OPCS[k];
        if ((r[6:0] == 7'h13 || r[6:0] == 7'h33)
            && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (r[6:0] == 7'h73 && $urandom_range(0, 1) != 0)
            r = ($urandom_range(0, 1) != 0) ? 32'h73 : 32'h0010_0073;
        return r;
    endfunction

    initial begin
        tbl[0]  = '{32'h0050_0093, 32'h5,          4'd0,  0,1,1,0,0,2'd0,0,0,0, 5'd1};
        tbl[1]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC,  4'd0,  1,1,0,0,0,2'd0,1,0,0, 5'd0};
        tbl[2]  = '{32'h1234_50B7, 32'h1234_5000,  4'd10, 0,1,1,0,0,2'd0,0,0,0, 5'd1};
        tbl[3]  = '{32'h4020_D093, 32'h402,        4'd7,  0,1,1,0,0,2'd0,0,0,0, 5'd1};
        tbl[4]  = '{32'hFFFF_FFFF, 32'h0,          4'd0,  0,0,0,0,0,2'd0,0,0,1, 5'd0};
        tbl[5]  = '{32'h0000_0033, 32'h0,          4'd0,  0,0,0,0,0,2'd0,0,0,0, 5'd0};
        tbl[6]  = '{32'h4020_8133, 32'h0,          4'd1,  0,0,1,0,0,2'd0,0,0,0, 5'd2};
        tbl[7]  = '{32'h0080_00EF, 32'h8,          4'd0,  1,1,1,0,0,2'd2,0,1,0, 5'd1};
        tbl[8]  = '{32'h00C1_2283, 32'hC,          4'd0,  0,1,1,1,0,2'd1,0,0,0, 5'd5};
        tbl[9]  = '{32'h0051_2423, 32'h8,          4'd0,  0,1,0,0,1,2'd0,0,0,0, 5'd0};
        tbl[10] = '{32'h0220_8133, 32'h0,          4'd0,  0,0,0,0,0,2'd0,0,0,1, 5'd0};
        tbl[11] = '{32'h0000_0073, 32'h0,          4'd0,  0,0,0,0,0,2'd0,0,0,0, 5'd0};
        tbl[12] = '{32'h0000_1097, 32'h1000,       4'd0,  1,1,1,0,0,2'd0,0,0,0, 5'd1};

        rst = 1'b0; en = 1'b1; flush = 1'b0;
        pc_i = '0; instr_i = NOP;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        exp_q = rst_val();

        #12;
        check("reset_state", 256'(got()), 256'(rst_val()));
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            instr_i = tbl[i].instr;
            pc_i    = 32'(i * 4);
            tick("tbl_model");
            if (tbl[i].illegal)
                check($sformatf("tbl%0d_ctrl", i),
                      256'({valid_o, regwen_o, memrd_o, memwr_o,
                            branch_o, jump_o, illegal_o}),
                      256'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
            else
                check($sformatf("tbl%0d", i),
                      256'({valid_o, imm_o, alu_op_o, asel_o, bsel_o,
                            regwen_o, memrd_o, memwr_o, wbsel_o,
                            branch_o, jump_o, illegal_o, rd_o}),
                      256'({1'b1, tbl[i].imm, tbl[i].alu,
                            tbl[i].asel, tbl[i].bsel, tbl[i].regwen,
                            tbl[i].memrd, tbl[i].memwr, tbl[i].wbsel,
                            tbl[i].branch, tbl[i].jump, 1'b0,
                            tbl[i].rd}));
        end

        // Write-through bypass on rs2, then a later read of x2.
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
        instr_i = 32'h0020_81B3;
        tick("wt_model");
        check("wt_rs2", 256'(rs2_data_o), 256'(32'hDEAD_BEEF));
        wb_we = 1'b0;
        instr_i = 32'h0001_0033;
        tick("wt_later_model");
        check("wt_later_rs1", 256'(rs1_data_o), 256'(32'hDEAD_BEEF));

        // Writes to x0 are dropped.
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        instr_i = 32'h0000_0033;
        tick("x0_model");
        wb_we = 1'b0;
        tick("x0_next_model");
        check("x0_rs_data", 256'({rs1_data_o, rs2_data_o}), 256'(64'd0));

        // Stall for three cycles while fetch moves on, then flush.
        instr_i = 32'h00C1_2283; pc_i = 32'h100;
        tick("stall_load");
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr_i = $urandom;
            pc_i    = $urandom;
            tick("stall_model");
            check("stall_hold", 256'({valid_o, pc_o, instr_o}),
                  256'({1'b1, 32'h100, 32'h00C1_2283}));
        end
        flush = 1'b1; pc_i = 32'h200;
        tick("flush_model");
        check("flush_bubble",
              256'({valid_o, instr_o, regwen_o, pc_o}),
              256'({1'b0, NOP, 1'b0, 32'h200}));
        flush = 1'b0; en = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            wb_we   = ($urandom_range(0, 1) != 0);
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            instr_i = rand_instr();
            instr_i[19:15] = ($urandom_range(0, 1) != 0)
                           ? wb_rd : 5'($urandom_range(0, 7));
            instr_i[24:20] = ($urandom_range(0, 1) != 0)
                           ? wb_rd : 5'($urandom_range(0, 7));
            pc_i  = $urandom & ~32'h3;
            en    = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        en = 1'b1; flush = 1'b0;

        // Asynchronous reset mid-cycle.
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55AA_1234;
        instr_i = NOP; pc_i = 32'h40;
        tick("ar_write");
        wb_we = 1'b0;
        instr_i = 32'h0000_8033;
        tick("ar_read_model");
        check("ar_before", 256'({valid_o, rs1_data_o}),
              256'({1'b1, 32'h55AA_1234}));
        #3;
        rst = 1'b0;
        #1;
        check("ar_valid_low", 256'(valid_o), 256'(1'b0));
        check("ar_state", 256'(got()), 256'(rst_val()));
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        exp_q = rst_val();
        #2;
        rst = 1'b1;
        tick("ar_after_model");
        check("ar_x1_cleared", 256'({valid_o, rs1_data_o}),
              256'({1'b1, 32'h0}));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
